// File: rtl/rr_ring_arbiter_if.sv
// Request/grant bundle for rr_ring_arbiter: requesters drive req/done (master),
// the arbiter drives the grant, ring pointer and timeout (slave).
interface rr_ring_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]   req;
    logic           done;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic [N-1:0]   ptr;
    logic           timeout;

    modport master (
        output req, done,
        input  gnt, gnt_valid, gnt_id, ptr, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_valid, gnt_id, ptr, timeout
    );
endinterface

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority ring; the grant is held until release.
// Optional hold-time limit enabled by defining ARB_TIMEOUT_EN.
module rr_ring_arbiter #(
    parameter int N        = 4,
    parameter int IDW      = (N > 1) ? $clog2(N) : 1,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    rr_ring_arbiter_if.slave  bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    generate
        if (N < 1 || MAX_HOLD < 1) begin : g_bad_params
            $error("rr_ring_arbiter: N and MAX_HOLD must both be >= 1");
        end
    endgenerate

    logic [0:0]     state;
    logic [N-1:0]   gnt_q;
    logic           gnt_valid_q;
    logic [IDW-1:0] gnt_id_q;
    logic [N-1:0]   ptr_q;
    logic           timeout_q;

    logic [IDW-1:0] ptr_idx;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] win_idx;
    logic [N-1:0]   win_onehot;
    logic           win_found;
    logic           release_now;
    logic           hold_expired;

    function automatic logic [N-1:0] rotl1(input logic [N-1:0] x);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[(i + 1) % N] = x[i];
        end
        return r;
    endfunction

    // Circular search starting at the ring position, wrapping N-1 -> 0.
    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr_q[i]) ptr_idx = IDW'(i);
        end
        cand       = '0;
        win_idx    = '0;
        win_onehot = '0;
        win_found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = IDW'((int'(ptr_idx) + k) % N);
            if (!win_found && bus.req[cand]) begin
                win_found           = 1'b1;
                win_idx             = cand;
                win_onehot[cand]    = 1'b1;
            end
        end
    end

    // The owner's own request is picked out by the grant mask.
    assign release_now = bus.done || ((bus.req & gnt_q) == '0);

`ifdef ARB_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    logic [HW-1:0] hold_cnt;

    // hold_cnt counts completed GRANT cycles, so the limit trips in grant cycle MAX_HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state != GRANT) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    assign hold_expired = (state == GRANT) && (hold_cnt == HW'(MAX_HOLD - 1));
`else
    assign hold_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ptr_q       <= N'(1);
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt_q       <= win_onehot;
                        gnt_id_q    <= win_idx;
                        gnt_valid_q <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now || hold_expired) begin
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= rotl1(gnt_q);
                        timeout_q   <= hold_expired && !release_now;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.ptr       = ptr_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Directed bench for rr_ring_arbiter (N=4, MAX_HOLD=8): vector table plus
// hand-written reset and hold-limit sequences.
module tb_rr_ring_arbiter;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rr_ring_arbiter_if #(.N(N)) bus ();

    rr_ring_arbiter #(.N(N), .MAX_HOLD(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic [3:0] ptr;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic [3:0] p, input logic to);
        check({tag, ".gnt"},       32'(bus.gnt),       32'(g));
        check({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(|g));
        check({tag, ".gnt_id"},    32'(bus.gnt_id),    32'(id));
        check({tag, ".ptr"},       32'(bus.ptr),       32'(p));
        check({tag, ".timeout"},   32'(bus.timeout),   32'(to));
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // req, done -> expected gnt, gnt_id, ptr after the next edge
        vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 4'b0001};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 4'b0010};
        vecs[2]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 4'b0010};
        vecs[3]  = '{4'b1111, 1'b1, 4'b0000, 2'd1, 4'b0100};
        vecs[4]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 4'b0100};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0000, 2'd2, 4'b1000};
        vecs[6]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 4'b1000};
        vecs[7]  = '{4'b1111, 1'b1, 4'b0000, 2'd3, 4'b0001};
        vecs[8]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 4'b0001};
        vecs[9]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 4'b0010};
        vecs[10] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 4'b0010};
        vecs[11] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 4'b0100};
        vecs[12] = '{4'b0011, 1'b0, 4'b0001, 2'd0, 4'b0100};
        vecs[13] = '{4'b0011, 1'b1, 4'b0000, 2'd0, 4'b0010};
        vecs[14] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0010};
        vecs[15] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 4'b0010};
        vecs[16] = '{4'b0101, 1'b0, 4'b0100, 2'd2, 4'b0010};
        vecs[17] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 4'b0010};
        vecs[18] = '{4'b0001, 1'b0, 4'b0000, 2'd2, 4'b1000};
        vecs[19] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 4'b1000};
        vecs[20] = '{4'b0000, 1'b1, 4'b0000, 2'd3, 4'b0001};
        vecs[21] = '{4'b0000, 1'b0, 4'b0000, 2'd3, 4'b0001};

        rst      = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 4'b0000, 2'd0, 4'b0001, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            bus.req  = vecs[i].req;
            bus.done = vecs[i].done;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].ptr, 1'b0);
        end

        // Asynchronous reset while requester 3 owns the grant.
        bus.done = 1'b0;
        bus.req  = 4'b0100;
        step();
        check_all("pre_rst_a", 4'b0100, 2'd2, 4'b0001, 1'b0);
        bus.done = 1'b1;
        step();
        check_all("pre_rst_b", 4'b0000, 2'd2, 4'b1000, 1'b0);
        bus.done = 1'b0;
        bus.req  = 4'b1000;
        step();
        check_all("pre_rst_c", 4'b1000, 2'd3, 4'b1000, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_all("async_rst", 4'b0000, 2'd0, 4'b0001, 1'b0);
        #1 rst = 1'b0;
        bus.req = 4'b1111;
        step();
        check_all("post_rst", 4'b0001, 2'd0, 4'b0001, 1'b0);
        bus.req = 4'b0000;
        step();
        check_all("post_rst_rel", 4'b0000, 2'd0, 4'b0010, 1'b0);

        // Requester 1 holds without ever signalling done.
        bus.req = 4'b0010;
        step();
        check_all("hold_c1", 4'b0010, 2'd1, 4'b0010, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int c = 2; c <= 8; c++) begin
            step();
            check_all($sformatf("hold_c%0d", c), 4'b0010, 2'd1, 4'b0010, 1'b0);
        end
        step();
        check_all("revoke", 4'b0000, 2'd1, 4'b0100, 1'b1);
        step();
        check_all("regrant", 4'b0010, 2'd1, 4'b0100, 1'b0);
`else
        for (int c = 2; c <= 25; c++) begin
            step();
            check_all($sformatf("hold_c%0d", c), 4'b0010, 2'd1, 4'b0010, 1'b0);
        end
        bus.req = 4'b0000;
        step();
        check_all("hold_rel", 4'b0000, 2'd1, 4'b0100, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
